calc_input_sequencer: RTL

CALC_INPUT_SEQUENCER -- requirements
Module: calc_input_sequencer

---
 rtl/calc_input_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/calc_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : calc_input_sequencer
//  Purpose  : Turns calculator key clicks into ALU requests. Digits build
//             operand A, an operator latches the opcode, digits build operand
//             B, '=' issues a valid/ready request, and the returned result
//             is captured for display and can seed the next calculation.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             newDigit, newOp   - level inputs, high while a square is clicked
//             keyCode[3:0]      - digit 0-9 or op 1=* 2=+ 3=- 4=/ 14='='
//             calc_ready        - ALU accepts request
//             result_valid      - one-cycle result pulse, result[15:0]
//             calc_valid        - request to ALU
//             operandA/B[15:0]  - operands, opCode[3:0] - operator
//             display_value     - value shown on screen
//             busy              - high while a request is outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module calc_input_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        newDigit,
    input  logic        newOp,
    input  logic [3:0]  keyCode,
    input  logic        calc_ready,
    input  logic        result_valid,
    input  logic [15:0] result,
    output logic        calc_valid,
    output logic [15:0] operandA,
    output logic [15:0] operandB,
    output logic [3:0]  opCode,
    output logic [15:0] display_value,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_SEEN = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT    = 3'd4,
        S_RESULT  = 3'd5
    } state_t;

    localparam logic [2:0] C_MAX_DIGITS = 3'd4;
    localparam logic [3:0] C_KEY_EQUAL  = 4'd14;

    state_t      r_state, w_state_d;
    logic [15:0] r_a, w_a_d;
    logic [15:0] r_b, w_b_d;
    logic [3:0]  r_op, w_op_d;
    logic [2:0]  r_cnt, w_cnt_d;
    logic [15:0] r_res, w_res_d;
    logic        r_prev;

    logic        w_press;
    logic        w_digit_ev;
    logic        w_arith_ev;
    logic        w_eq_ev;
    logic        w_room;
    logic [15:0] w_a_acc;
    logic [15:0] w_b_acc;
    logic [15:0] w_key16;

    // A press is the rising edge of "any square clicked"; both lines high at
    // once is ambiguous and is dropped, but still arms the prev flag.
    assign w_press    = (newDigit ^ newOp) && !r_prev;
    assign w_digit_ev = w_press && newDigit && (keyCode <= 4'd9);
    assign w_arith_ev = w_press && newOp && (keyCode >= 4'd1) && (keyCode <= 4'd4);
    assign w_eq_ev    = w_press && newOp && (keyCode == C_KEY_EQUAL);
    assign w_room     = (r_cnt < C_MAX_DIGITS);
    assign w_key16    = {12'd0, keyCode};
    // Four digits max keeps the value at 9999, so no 16-bit overflow.
    assign w_a_acc    = (r_a * 16'd10) + w_key16;
    assign w_b_acc    = (r_b * 16'd10) + w_key16;

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_op_d    = r_op;
        w_cnt_d   = r_cnt;
        w_res_d   = r_res;
        case (r_state)
            S_ENTER_A: begin
                if (w_digit_ev && w_room) begin
                    w_a_d   = w_a_acc;
                    w_cnt_d = r_cnt + 3'd1;
                end else if (w_arith_ev) begin
                    w_op_d    = keyCode;
                    w_state_d = S_OP_SEEN;
                end
            end
            S_OP_SEEN: begin
                if (w_digit_ev) begin
                    w_b_d     = w_key16;
                    w_cnt_d   = 3'd1;
                    w_state_d = S_ENTER_B;
                end else if (w_arith_ev) begin
                    w_op_d = keyCode;
                end
            end
            S_ENTER_B: begin
                if (w_digit_ev && w_room) begin
                    w_b_d   = w_b_acc;
                    w_cnt_d = r_cnt + 3'd1;
                end else if (w_eq_ev) begin
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (calc_ready) begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (result_valid) begin
                    w_res_d   = result;
                    w_state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (w_digit_ev) begin
                    w_a_d     = w_key16;
                    w_b_d     = 16'd0;
                    w_cnt_d   = 3'd1;
                    w_state_d = S_ENTER_A;
                end else if (w_arith_ev) begin
                    // Chain the previous result as the new left operand.
                    w_a_d     = r_res;
                    w_op_d    = keyCode;
                    w_state_d = S_OP_SEEN;
                end
            end
            default: begin
                w_state_d = S_ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ENTER_A;
            r_a     <= 16'd0;
            r_b     <= 16'd0;
            r_op    <= 4'd0;
            r_cnt   <= 3'd0;
            r_res   <= 16'd0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_op    <= w_op_d;
            r_cnt   <= w_cnt_d;
            r_res   <= w_res_d;
            r_prev  <= newDigit | newOp;
        end
    end

    assign calc_valid = (r_state == S_EXEC);
    assign busy       = (r_state == S_EXEC) || (r_state == S_WAIT);
    assign operandA   = r_a;
    assign operandB   = r_b;
    assign opCode     = r_op;

    always_comb begin
        display_value = r_a;
        case (r_state)
            S_ENTER_B, S_EXEC, S_WAIT: display_value = r_b;
            S_RESULT:                  display_value = r_res;
            default:                   display_value = r_a;
        endcase
    end

endmodule
`default_nettype wire
